delay_probe: RTL and testbench

- Measuring end of the delayed-copy path. Each of three channels watches a launch-side value (src_*) and its delayed copy (obs_*).
- Reports, in clk cycles, how long the copy took to match the launched value. Flags a timeout if it never matches.
- Sits beside any delay or pipeline stage under test, inside sequential test harnesses. Verifies per-channel latency without `#` delays.

---
 rtl/delay_probe_pkg.sv | 14 +
 rtl/delay_probe_ch.sv | 102 ++++++++++
 rtl/delay_probe.sv | 57 +++++
 tb/tb_delay_probe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_probe_pkg.sv
// Shared types and defaults for the delayed-copy latency probe.
package delay_probe_pkg;
  localparam int NUM_CH       = 3;
  localparam int DEF_W        = 3;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_MAX_WAIT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    TMO  = 2'd3
  } probe_state_t;
endpackage

// File: rtl/delay_probe_ch.sv
// One probe channel: times launch (src change) to first obs match, in clk edges.
// All outputs registered; no backpressure. Optional max-hold via DELAY_PROBE_MAXHOLD_EN.
module delay_probe_ch
  import delay_probe_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [W-1:0]     src,
  input  logic [W-1:0]     obs,
  output logic [CNT_W-1:0] lat,
  output logic             busy,
  output logic             done,
  output logic             timeout
`ifdef DELAY_PROBE_MAXHOLD_EN
  ,
  output logic [CNT_W-1:0] lat_max
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  probe_state_t     state, state_n;
  logic [W-1:0]     src_q, expected, expected_n;
  logic [CNT_W-1:0] cnt, cnt_n, lat_n;
  logic             launch, commit;

  assign launch = (src != src_q);

  always_comb begin
    state_n    = state;
    expected_n = expected;
    cnt_n      = cnt;
    lat_n      = lat;
    commit     = 1'b0;
    if (clear) begin
      state_n = IDLE;
      cnt_n   = '0;
      lat_n   = '0;
    end else if (launch) begin
      expected_n = src;
      cnt_n      = ONE;
      if (obs == src) begin
        state_n = DONE;
        lat_n   = '0;
        commit  = 1'b1;
      end else begin
        state_n = WAIT;
      end
    end else if (state == WAIT) begin
      if (obs == expected) begin
        state_n = DONE;
        lat_n   = cnt;
        commit  = 1'b1;
      end else if (cnt == MAX_CNT) begin
        state_n = TMO;
        lat_n   = MAX_CNT;
      end else begin
        cnt_n = cnt + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      src_q    <= '0;
      expected <= '0;
      cnt      <= '0;
      lat      <= '0;
    end else begin
      state    <= state_n;
      src_q    <= src;
      expected <= expected_n;
      cnt      <= cnt_n;
      lat      <= lat_n;
    end
  end

  // Status bits decode the registered state, so they are themselves registered.
  assign busy    = (state == WAIT);
  assign done    = (state == DONE);
  assign timeout = (state == TMO);

`ifdef DELAY_PROBE_MAXHOLD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_max <= '0;
    end else if (clear) begin
      lat_max <= '0;
    end else if (commit && (lat_n > lat_max)) begin
      lat_max <= lat_n;
    end
  end
`endif

endmodule

// File: rtl/delay_probe.sv
// Three independent latency probe channels; optional per-channel max-hold under DELAY_PROBE_MAXHOLD_EN.
// Outputs registered, one-edge update; no backpressure.
module delay_probe
  import delay_probe_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [W-1:0]      src_a,
  input  logic [W-1:0]      src_b,
  input  logic [W-1:0]      src_c,
  input  logic [W-1:0]      obs_d,
  input  logic [W-1:0]      obs_e,
  input  logic [W-1:0]      obs_f,
  output logic [CNT_W-1:0]  lat_d,
  output logic [CNT_W-1:0]  lat_e,
  output logic [CNT_W-1:0]  lat_f,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done,
  output logic [NUM_CH-1:0] timeout
`ifdef DELAY_PROBE_MAXHOLD_EN
  ,
  output logic [CNT_W-1:0]  lat_max_d,
  output logic [CNT_W-1:0]  lat_max_e,
  output logic [CNT_W-1:0]  lat_max_f
`endif
);

  delay_probe_ch #(.W(W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) u_ch0 (
    .clk(clk), .reset(reset), .clear(clear), .src(src_a), .obs(obs_d),
    .lat(lat_d), .busy(busy[0]), .done(done[0]), .timeout(timeout[0])
`ifdef DELAY_PROBE_MAXHOLD_EN
    , .lat_max(lat_max_d)
`endif
  );

  delay_probe_ch #(.W(W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) u_ch1 (
    .clk(clk), .reset(reset), .clear(clear), .src(src_b), .obs(obs_e),
    .lat(lat_e), .busy(busy[1]), .done(done[1]), .timeout(timeout[1])
`ifdef DELAY_PROBE_MAXHOLD_EN
    , .lat_max(lat_max_e)
`endif
  );

  delay_probe_ch #(.W(W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) u_ch2 (
    .clk(clk), .reset(reset), .clear(clear), .src(src_c), .obs(obs_f),
    .lat(lat_f), .busy(busy[2]), .done(done[2]), .timeout(timeout[2])
`ifdef DELAY_PROBE_MAXHOLD_EN
    , .lat_max(lat_max_f)
`endif
  );

endmodule

// File: tb/tb_delay_probe.sv
// Bench for delay_probe: directed scenarios plus random traffic against an elapsed-time reference model.
module tb_delay_probe;
  localparam int W        = 3;
  localparam int CNT_W    = 8;
  localparam int MAX_WAIT = 255;
  localparam int S_IDLE = 0, S_WAIT = 1, S_DONE = 2, S_TMO = 3;

  logic clk = 1'b0;
  logic reset, clear;
  logic [W-1:0] src_a, src_b, src_c, obs_d, obs_e, obs_f;
  logic [CNT_W-1:0] lat_d, lat_e, lat_f;
  logic [2:0] busy, done, timeout;
`ifdef DELAY_PROBE_MAXHOLD_EN
  logic [CNT_W-1:0] lat_max_d, lat_max_e, lat_max_f;
`endif

  delay_probe #(.W(W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .src_a(src_a), .src_b(src_b), .src_c(src_c),
    .obs_d(obs_d), .obs_e(obs_e), .obs_f(obs_f),
    .lat_d(lat_d), .lat_e(lat_e), .lat_f(lat_f),
    .busy(busy), .done(done), .timeout(timeout)
`ifdef DELAY_PROBE_MAXHOLD_EN
    , .lat_max_d(lat_max_d), .lat_max_e(lat_max_e), .lat_max_f(lat_max_f)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Stimulus and reference model state (model works on edge timestamps).
  logic [W-1:0] s[3], o[3];
  logic [W-1:0] m_prev[3], m_exp[3];
  int m_t0[3], m_st[3], m_lat[3], m_max[3];
  int edge_n = 0;

  task automatic apply();
    src_a = s[0]; src_b = s[1]; src_c = s[2];
    obs_d = o[0]; obs_e = o[1]; obs_f = o[2];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_prev[i] = '0; m_exp[i] = '0; m_t0[i] = 0;
      m_st[i] = S_IDLE; m_lat[i] = 0; m_max[i] = 0;
    end
  endtask

  task automatic model_step(input logic clr);
    for (int i = 0; i < 3; i++) begin
      logic launch;
      int el;
      launch = (s[i] != m_prev[i]);
      m_prev[i] = s[i];
      if (clr) begin
        m_st[i] = S_IDLE; m_lat[i] = 0; m_max[i] = 0;
      end else if (launch) begin
        m_exp[i] = s[i];
        m_t0[i] = edge_n;
        if (o[i] == s[i]) begin
          m_st[i] = S_DONE; m_lat[i] = 0;
        end else begin
          m_st[i] = S_WAIT;
        end
      end else if (m_st[i] == S_WAIT) begin
        el = edge_n - m_t0[i];
        if (o[i] == m_exp[i]) begin
          m_st[i] = S_DONE; m_lat[i] = el;
          if (el > m_max[i]) m_max[i] = el;
        end else if (el >= MAX_WAIT) begin
          m_st[i] = S_TMO; m_lat[i] = MAX_WAIT;
        end
      end
    end
  endtask

  task automatic compare_all(input string ph);
    int lv[3];
    lv[0] = int'(lat_d); lv[1] = int'(lat_e); lv[2] = int'(lat_f);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s.lat%0d", ph, i), lv[i], m_lat[i]);
      check($sformatf("%s.busy%0d", ph, i), int'(busy[i]), int'(m_st[i] == S_WAIT));
      check($sformatf("%s.done%0d", ph, i), int'(done[i]), int'(m_st[i] == S_DONE));
      check($sformatf("%s.tmo%0d", ph, i), int'(timeout[i]), int'(m_st[i] == S_TMO));
    end
`ifdef DELAY_PROBE_MAXHOLD_EN
    check($sformatf("%s.max0", ph), int'(lat_max_d), m_max[0]);
    check($sformatf("%s.max1", ph), int'(lat_max_e), m_max[1]);
    check($sformatf("%s.max2", ph), int'(lat_max_f), m_max[2]);
`endif
  endtask

  // Inputs are set at the falling edge; the model advances with the rising edge.
  task automatic tick(input logic clr, input string ph);
    apply();
    clear = clr;
    model_step(clr);
    @(posedge clk);
    @(negedge clk);
    edge_n++;
    compare_all(ph);
  endtask

  task automatic run_lat(input logic [W-1:0] v, input int l);
    s[0] = v; o[0] = '0;
    tick(1'b0, "seq");
    repeat (l - 1) tick(1'b0, "seq");
    o[0] = v;
    tick(1'b0, "seq");
    check("seq.lat_d", int'(lat_d), l);
  endtask

  logic [W-1:0] hist[3][8];
  int dly[3];

  initial begin
    for (int i = 0; i < 3; i++) begin s[i] = '0; o[i] = '0; end
    apply();
    clear = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all("rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick(1'b0, "idle");

    // Async reset while channel 0 waits; src returns to 0 so nothing relaunches.
    s[0] = 3'd4;
    tick(1'b0, "rw");
    tick(1'b0, "rw");
    check("rw.busy0_before", int'(busy[0]), 1);
    reset = 1'b1;
    #1;
    check("rw.busy_async", int'(busy), 0);
    check("rw.done_async", int'(done), 0);
    check("rw.lat_async", int'(lat_d), 0);
    model_reset();
    s[0] = '0;
    apply();
    @(negedge clk);
    reset = 1'b0;
    tick(1'b0, "rw");
    tick(1'b0, "rw");
    check("rw.no_done", int'(done), 0);

    // Fixed delay of three edges.
    s[0] = 3'd4;
    tick(1'b0, "fix");
    tick(1'b0, "fix");
    tick(1'b0, "fix");
    o[0] = 3'd4;
    tick(1'b0, "fix");
    check("fix.lat_d", int'(lat_d), 3);
    check("fix.done0", int'(done[0]), 1);
    check("fix.busy0", int'(busy[0]), 0);

    // Zero latency on ch1 and full timeout on ch2, launched together.
    s[1] = 3'd5; o[1] = 3'd5;
    s[2] = 3'd6; o[2] = 3'd0;
    tick(1'b0, "zt");
    check("zt.lat_e", int'(lat_e), 0);
    check("zt.done1", int'(done[1]), 1);
    repeat (MAX_WAIT - 1) tick(1'b0, "zt");
    check("zt.busy2_last", int'(busy[2]), 1);
    tick(1'b0, "zt");
    check("zt.tmo2", int'(timeout[2]), 1);
    check("zt.lat_f", int'(lat_f), MAX_WAIT);
    check("zt.done0_kept", int'(done[0]), 1);

    // Re-launch in the middle of a wait.
    s[0] = 3'd7; o[0] = 3'd0;
    tick(1'b0, "rl");
    tick(1'b0, "rl");
    s[0] = 3'd1;
    tick(1'b0, "rl");
    tick(1'b0, "rl");
    o[0] = 3'd1;
    tick(1'b0, "rl");
    check("rl.lat_d", int'(lat_d), 2);
    check("rl.tmo0", int'(timeout[0]), 0);

    // Clear on the same edge as a src change.
    s[1] = 3'd2; o[1] = 3'd2;
    tick(1'b1, "clr");
    check("clr.done", int'(done), 0);
    check("clr.tmo", int'(timeout), 0);
    tick(1'b0, "clr");
    check("clr.no_launch", int'(done[1] | busy[1]), 0);

    // Latency sequence 3, 7, 2, then a timeout, then clear.
    run_lat(3'd3, 3);
`ifdef DELAY_PROBE_MAXHOLD_EN
    check("mh.max_a", int'(lat_max_d), 3);
`endif
    run_lat(3'd5, 7);
`ifdef DELAY_PROBE_MAXHOLD_EN
    check("mh.max_b", int'(lat_max_d), 7);
`endif
    run_lat(3'd2, 2);
`ifdef DELAY_PROBE_MAXHOLD_EN
    check("mh.max_c", int'(lat_max_d), 7);
`endif
    s[0] = 3'd6; o[0] = 3'd0;
    repeat (MAX_WAIT + 1) tick(1'b0, "mh");
    check("mh.tmo0", int'(timeout[0]), 1);
`ifdef DELAY_PROBE_MAXHOLD_EN
    check("mh.max_tmo", int'(lat_max_d), 7);
`endif
    tick(1'b1, "mh");
`ifdef DELAY_PROBE_MAXHOLD_EN
    check("mh.max_clr", int'(lat_max_d), 0);
`endif

    // Random traffic: obs is a delayed copy of src with occasional noise.
    for (int i = 0; i < 3; i++) begin
      dly[i] = 1;
      for (int j = 0; j < 8; j++) hist[i][j] = s[i];
    end
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 3) == 0) s[i] = W'($urandom);
        for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = s[i];
        if ($urandom_range(0, 15) == 0) dly[i] = int'($urandom_range(0, 7));
        if ($urandom_range(0, 9) == 0) o[i] = W'($urandom);
        else o[i] = hist[i][dly[i]];
      end
      tick(($urandom_range(0, 49) == 0), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
